pwm_bank: RTL and testbench

PWM_BANK -- requirements
Module: pwm_bank

---
 rtl/pwm_bank_pkg.sv | 28 ++
 rtl/pwm_ch.sv | 89 ++++++++
 rtl/pwm_bank.sv | 98 +++++++++
 tb/tb_pwm_bank.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_bank_pkg.sv
// ============================================================================
// Module   : pwm_bank_pkg
// Brief    : Shared types and constant helpers for the PWM bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pwm_bank_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_RAMP   = 1'b1
    } pwm_mode_e;

    // Full-scale code scaled by a percentage, truncating integer division.
    function automatic longint pct_of_full(input int width, input int pct);
        longint full;
        full = (longint'(1) << width) - longint'(1);
        return (full * longint'(pct)) / longint'(100);
    endfunction

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_ch.sv
// ============================================================================
// Module   : pwm_ch
// Brief    : One PWM channel: clamped target, mode, active duty with ramp.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_ch
    import pwm_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] BR_MIN    = '0,
    parameter logic [WIDTH-1:0] BR_MAX    = '1,
    parameter int               RAMP_STEP = 1
) (
    input  logic             sysclk,
    input  logic             i_rst_n,
    input  logic             i_enb,
    input  logic             i_commit,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_duty,
    input  logic             i_wr_ramp,
    input  logic [WIDTH-1:0] i_cnt_next,
    output logic             o_pwm
);

    localparam logic [WIDTH:0] STEP = (WIDTH+1)'(RAMP_STEP);

    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_active;
    pwm_mode_e        r_mode;
    logic             r_pwm;

    logic [WIDTH-1:0] w_duty_clamped;
    logic [WIDTH-1:0] w_active_next;
    logic [WIDTH:0]   w_up;
    logic [WIDTH:0]   w_tgt_step;

    // One extra bit so a step near full scale cannot wrap.
    assign w_up       = {1'b0, r_active} + STEP;
    assign w_tgt_step = {1'b0, r_target} + STEP;

    always_comb begin
        w_duty_clamped = i_wr_duty;
        if (i_wr_duty < BR_MIN) begin
            w_duty_clamped = BR_MIN;
        end else if (i_wr_duty > BR_MAX) begin
            w_duty_clamped = BR_MAX;
        end
    end

    always_comb begin
        w_active_next = r_active;
        if (!i_enb) begin
            w_active_next = r_target;
        end else if (i_commit) begin
            if (r_mode == MODE_DIRECT) begin
                w_active_next = r_target;
            end else if (r_active < r_target) begin
                w_active_next = (w_up >= {1'b0, r_target}) ? r_target : w_up[WIDTH-1:0];
            end else if (r_active > r_target) begin
                w_active_next = ({1'b0, r_active} <= w_tgt_step) ? r_target
                                                                 : (r_active - STEP[WIDTH-1:0]);
            end
        end
    end

    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_target <= BR_MIN;
            r_active <= BR_MIN;
            r_mode   <= MODE_DIRECT;
            r_pwm    <= 1'b0;
        end else begin
            if (i_wr_en) begin
                r_target <= w_duty_clamped;
                r_mode   <= i_wr_ramp ? MODE_RAMP : MODE_DIRECT;
            end
            r_active <= w_active_next;
            // Compare against the count the period will show after this edge.
            r_pwm    <= i_enb && (i_cnt_next < w_active_next);
        end
    end

    assign o_pwm = r_pwm;

endmodule

`default_nettype wire

// File: rtl/pwm_bank.sv
// ============================================================================
// Module   : pwm_bank
// Brief    : Multi-channel PWM with shared period counter and duty writes
//            committed only at period boundaries.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef BRIGHTNESS_WIDTH
`define BRIGHTNESS_WIDTH 8
`endif
`ifndef LED_MIN_BRIGHTNESS
`define LED_MIN_BRIGHTNESS 10
`endif
`ifndef LED_MAX_BRIGHTNESS
`define LED_MAX_BRIGHTNESS 90
`endif

module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int  N_CH      = 3,
    parameter int  WIDTH     = `BRIGHTNESS_WIDTH,
    parameter int  MIN_PCT   = `LED_MIN_BRIGHTNESS,
    parameter int  MAX_PCT   = `LED_MAX_BRIGHTNESS,
    parameter int  RAMP_STEP = 1,
    localparam int CW        = ch_width(N_CH)
) (
    input  logic             sysclk,
    input  logic             i_rst_n,
    input  logic             i_enb,
    input  logic             i_wr_vld,
    input  logic [CW-1:0]    i_wr_ch,
    input  logic [WIDTH-1:0] i_wr_duty,
    input  logic             i_wr_ramp,
    output logic             o_wr_rdy,
    output logic [N_CH-1:0]  o_pwm,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_period_end
);

    localparam logic [WIDTH-1:0] BR_MIN   = WIDTH'(pct_of_full(WIDTH, MIN_PCT));
    localparam logic [WIDTH-1:0] BR_MAX   = WIDTH'(pct_of_full(WIDTH, MAX_PCT));
    localparam logic [WIDTH-1:0] CNT_LAST = '1;
    localparam logic [CW:0]      N_CH_V   = (CW+1)'(N_CH);

    logic [WIDTH-1:0] r_cnt;
    logic             r_period_end;

    logic [WIDTH-1:0] w_cnt_next;
    logic             w_commit;
    logic             w_wr_accept;

    assign w_cnt_next  = r_cnt + WIDTH'(1);
    assign w_commit    = i_enb && (r_cnt == CNT_LAST);
    assign o_wr_rdy    = !w_commit;
    // Out-of-range channel writes are handshaken but land nowhere.
    assign w_wr_accept = i_wr_vld && o_wr_rdy && ({1'b0, i_wr_ch} < N_CH_V);

    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt        <= CNT_LAST;
            r_period_end <= 1'b0;
        end else begin
            r_cnt        <= i_enb ? w_cnt_next : CNT_LAST;
            r_period_end <= w_commit;
        end
    end

    assign o_cnt        = r_cnt;
    assign o_period_end = r_period_end;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic w_wr_en;

        assign w_wr_en = w_wr_accept && ({1'b0, i_wr_ch} == (CW+1)'(g));

        pwm_ch #(
            .WIDTH     (WIDTH),
            .BR_MIN    (BR_MIN),
            .BR_MAX    (BR_MAX),
            .RAMP_STEP (RAMP_STEP)
        ) u_ch (
            .sysclk     (sysclk),
            .i_rst_n    (i_rst_n),
            .i_enb      (i_enb),
            .i_commit   (w_commit),
            .i_wr_en    (w_wr_en),
            .i_wr_duty  (i_wr_duty),
            .i_wr_ramp  (i_wr_ramp),
            .i_cnt_next (w_cnt_next),
            .o_pwm      (o_pwm[g])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_pwm_bank.sv
// ============================================================================
// Module   : tb_pwm_bank
// Brief    : Scoreboard bench for pwm_bank; a period-level reference model
//            queues expected duties, a monitor measures each PWM period.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pwm_bank;

    localparam int NCH   = 3;
    localparam int FULL  = 256;
    localparam int LAST  = 255;
    localparam int BRMIN = 25;
    localparam int BRMAX = 229;
    localparam int STEP  = 1;

    logic       sysclk    = 1'b0;
    logic       i_rst_n   = 1'b1;
    logic       i_enb     = 1'b0;
    logic       i_wr_vld  = 1'b0;
    logic [1:0] i_wr_ch   = '0;
    logic [7:0] i_wr_duty = '0;
    logic       i_wr_ramp = 1'b0;
    wire        o_wr_rdy;
    wire  [2:0] o_pwm;
    wire  [7:0] o_cnt;
    wire        o_period_end;

    pwm_bank #(
        .N_CH      (3),
        .WIDTH     (8),
        .MIN_PCT   (10),
        .MAX_PCT   (90),
        .RAMP_STEP (STEP)
    ) dut (
        .sysclk       (sysclk),
        .i_rst_n      (i_rst_n),
        .i_enb        (i_enb),
        .i_wr_vld     (i_wr_vld),
        .i_wr_ch      (i_wr_ch),
        .i_wr_duty    (i_wr_duty),
        .i_wr_ramp    (i_wr_ramp),
        .o_wr_rdy     (o_wr_rdy),
        .o_pwm        (o_pwm),
        .o_cnt        (o_cnt),
        .o_period_end (o_period_end)
    );

    always #5 sysclk = ~sysclk;

    int checks       = 0;
    int failures     = 0;
    int periods_done = 0;

    // Reference model: channel state at period granularity.
    int          m_target[NCH];
    int          m_active[NCH];
    bit          m_ramp[NCH];
    int          m_cnt;
    bit          m_acc;
    logic [23:0] exp_q[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int clampd(input int d);
        if (d < BRMIN) return BRMIN;
        if (d > BRMAX) return BRMAX;
        return d;
    endfunction

    function automatic int dsel(input logic [23:0] e, input int c);
        return int'((e >> (8 * c)) & 24'hFF);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_target[c] = BRMIN;
            m_active[c] = BRMIN;
            m_ramp[c]   = 1'b0;
        end
        m_cnt = LAST;
        exp_q.delete();
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input bit enb, input bit vld, input int ch, input int duty,
                              input bit ramp, output bit commit);
        commit = enb && (m_cnt == LAST);
        m_acc  = vld && !commit && (ch < NCH);
        if (!enb) begin
            for (int c = 0; c < NCH; c++) m_active[c] = m_target[c];
            m_cnt = LAST;
        end else begin
            if (commit) begin
                for (int c = 0; c < NCH; c++) begin
                    if (!m_ramp[c])                   m_active[c] = m_target[c];
                    else if (m_active[c] < m_target[c])
                        m_active[c] = (m_active[c] + STEP > m_target[c]) ? m_target[c] : m_active[c] + STEP;
                    else if (m_active[c] > m_target[c])
                        m_active[c] = (m_active[c] - STEP < m_target[c]) ? m_target[c] : m_active[c] - STEP;
                end
                exp_q.push_back({8'(m_active[2]), 8'(m_active[1]), 8'(m_active[0])});
            end
            m_cnt = (m_cnt + 1) % FULL;
        end
        if (m_acc) begin
            m_target[ch] = clampd(duty);
            m_ramp[ch]   = ramp;
        end
    endtask

    task automatic drive(input bit enb, input bit vld, input int ch, input int duty, input bit ramp);
        bit commit;
        @(negedge sysclk);
        i_enb     = enb;
        i_wr_vld  = vld;
        i_wr_ch   = 2'(ch);
        i_wr_duty = 8'(duty);
        i_wr_ramp = ramp;
        model_step(enb, vld, ch, duty, ramp, commit);
        #1;
        check("wr_rdy", int'(o_wr_rdy), int'(!commit));
    endtask

    task automatic idle(input int n, input bit enb);
        repeat (n) drive(enb, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic write(input int ch, input int duty, input bit ramp);
        drive(1'b1, 1'b1, ch, duty, ramp);
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        while (m_cnt != v && n < 300) begin
            idle(1, 1'b1);
            n++;
        end
        check("wait_cnt_reached", m_cnt, v);
    endtask

    task automatic reset_pulse();
        bit commit;
        @(negedge sysclk);
        i_enb    = 1'b1;
        i_wr_vld = 1'b0;
        #1 i_rst_n = 1'b0;
        #1;
        check("async_rst_cnt", int'(o_cnt), LAST);
        check("async_rst_pwm", int'(o_pwm), 0);
        check("async_rst_pend", int'(o_period_end), 0);
        #1 i_rst_n = 1'b1;
        model_reset();
        model_step(1'b1, 1'b0, 0, 0, 1'b0, commit);
    endtask

    // Monitor: measure each period announced by o_period_end.
    initial begin : monitor
        bit          meas;
        int          idx;
        int          highs[NCH];
        int          serr[NCH];
        logic [23:0] e;
        meas = 1'b0;
        idx  = 0;
        e    = '0;
        forever begin
            @(negedge sysclk);
            if (i_rst_n && o_period_end) begin
                check("period_start_cnt", int'(o_cnt), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_period_end actual=pulse required=none at t=%0t", $time);
                    meas = 1'b0;
                end else begin
                    e    = exp_q.pop_front();
                    meas = 1'b1;
                    idx  = 0;
                    for (int c = 0; c < NCH; c++) begin
                        highs[c] = 0;
                        serr[c]  = 0;
                    end
                end
            end
            if (meas) begin
                if (int'(o_cnt) != idx) begin
                    meas = 1'b0;
                end else begin
                    for (int c = 0; c < NCH; c++) begin
                        if (o_pwm[c]) highs[c]++;
                        if (o_pwm[c] != (idx < dsel(e, c))) serr[c]++;
                    end
                    if (idx == LAST) begin
                        for (int c = 0; c < NCH; c++) begin
                            check($sformatf("high_time_ch%0d", c), highs[c], dsel(e, c));
                            check($sformatf("pwm_shape_errs_ch%0d", c), serr[c], 0);
                        end
                        periods_done++;
                        meas = 1'b0;
                    end
                    idx++;
                end
            end
        end
    end

    initial begin : stimulus
        int attempts;
        model_reset();
        #1 i_rst_n = 1'b0;
        #2;
        check("reset_cnt", int'(o_cnt), LAST);
        check("reset_pwm", int'(o_pwm), 0);
        check("reset_pend", int'(o_period_end), 0);
        check("reset_rdy", int'(o_wr_rdy), 1);
        @(negedge sysclk);
        #2 i_rst_n = 1'b1;

        // Enable, then ch0 = 128 direct.
        idle(1, 1'b1);
        write(0, 128, 1'b0);
        idle(600, 1'b1);

        // Clamp below and above.
        write(1, 5, 1'b0);
        write(2, 255, 1'b0);
        idle(300, 1'b1);

        // ch0 back to 25, then ramp to 30.
        write(0, 25, 1'b0);
        wait_cnt(10);
        wait_cnt(10);
        write(0, 30, 1'b1);
        idle(FULL * 7, 1'b1);

        // Write held across the commit cycle.
        wait_cnt(LAST);
        attempts = 0;
        do begin
            drive(1'b1, 1'b1, 1, 100, 1'b0);
            attempts++;
        end while (!m_acc && attempts < 4);
        check("held_write_attempts", attempts, 2);
        idle(600, 1'b1);

        // Disable at o_cnt = 100, change a target, re-enable.
        wait_cnt(100);
        idle(1, 1'b0);
        @(posedge sysclk);
        #1;
        check("disable_cnt", int'(o_cnt), LAST);
        check("disable_pwm", int'(o_pwm), 0);
        idle(3, 1'b0);
        drive(1'b0, 1'b1, 2, 200, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        @(posedge sysclk);
        #1;
        check("reenable_cnt", int'(o_cnt), 0);
        idle(400, 1'b1);

        // Reset mid-ramp, then an out-of-range channel write.
        write(1, 229, 1'b1);
        wait_cnt(10);
        wait_cnt(50);
        reset_pulse();
        write(3, 200, 1'b0);
        idle(600, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 6)       write(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            else if (r == 99) idle(int'($urandom_range(1, 5)), 1'b0);
            else              idle(1, 1'b1);
        end
        idle(600, 1'b1);

        check("periods_completed_min", int'(periods_done >= 15), 1);
        check("exp_queue_drained", int'(exp_q.size() <= 1), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
